// File: rtl/mem_ctrl_axil_regs.sv
// AXI4-Lite slave with four 32-bit control registers exported to the memory controller.
// Optional MEM_CTRL_AXIL_SLVERR_EN: unmapped slots answer SLVERR instead of OKAY.
//
// state     | meaning
// W_IDLE    | AWREADY/WREADY high, waiting for address and/or data
// W_COLLECT | one of AW/W captured, waiting for the other
// W_RESP    | register committed, BVALID held until BREADY
// R_IDLE    | ARREADY high, waiting for a read address
// R_DATA    | RVALID held with RDATA/RRESP until RREADY
module mem_ctrl_axil_regs #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 5
) (
  input  logic                            ACLK,
  input  logic                            ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   AWADDR,
  input  logic [2:0]                      AWPROT,
  input  logic                            AWVALID,
  output logic                            AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] WSTRB,
  input  logic                            WVALID,
  output logic                            WREADY,
  output logic [1:0]                      BRESP,
  output logic                            BVALID,
  input  logic                            BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   ARADDR,
  input  logic [2:0]                      ARPROT,
  input  logic                            ARVALID,
  output logic                            ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   RDATA,
  output logic [1:0]                      RRESP,
  output logic                            RVALID,
  input  logic                            RREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   slv_reg0,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   slv_reg1,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   slv_reg2,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   slv_reg3
);

`ifdef MEM_CTRL_AXIL_SLVERR_EN
  localparam logic SLVERR_EN = 1'b1;
`else
  localparam logic SLVERR_EN = 1'b0;
`endif

  localparam int DW = C_S_AXI_DATA_WIDTH;
  localparam int SW = C_S_AXI_DATA_WIDTH / 8;

  typedef enum logic [1:0] {W_IDLE, W_COLLECT, W_RESP} w_state_e;
  typedef enum logic {R_IDLE, R_DATA} r_state_e;

  w_state_e        w_state_q, w_state_d;
  r_state_e        r_state_q, r_state_d;
  logic            awready_q, awready_d;
  logic            wready_q, wready_d;
  logic            bvalid_q, bvalid_d;
  logic [1:0]      bresp_q, bresp_d;
  logic [2:0]      awslot_q, awslot_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [SW-1:0]   wstrb_q, wstrb_d;
  logic            arready_q, arready_d;
  logic            rvalid_q, rvalid_d;
  logic [1:0]      rresp_q, rresp_d;
  logic [DW-1:0]   rdata_q, rdata_d;
  logic [DW-1:0]   reg_q [4];
  logic [DW-1:0]   reg_d [4];

  logic            aw_hs, w_hs, ar_hs, commit;
  logic [2:0]      arslot;
  logic            unused_ok;

  assign aw_hs  = AWVALID & awready_q;
  assign w_hs   = WVALID & wready_q;
  assign ar_hs  = ARVALID & arready_q;
  assign arslot = ARADDR[4:2];
  assign unused_ok = ^{AWPROT, ARPROT, AWADDR[1:0], ARADDR[1:0]};

  always_comb begin
    w_state_d = w_state_q;
    awready_d = awready_q;
    wready_d  = wready_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    awslot_d  = awslot_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    commit    = 1'b0;
    for (int i = 0; i < 4; i++) reg_d[i] = reg_q[i];

    // Captured values feed the commit directly so a same-cycle AW+W commits on that edge.
    if (aw_hs) awslot_d = AWADDR[4:2];
    if (w_hs) begin
      wdata_d = WDATA;
      wstrb_d = WSTRB;
    end

    case (w_state_q)
      W_IDLE: begin
        if (aw_hs && w_hs) begin
          commit    = 1'b1;
          awready_d = 1'b0;
          wready_d  = 1'b0;
          w_state_d = W_RESP;
        end else if (aw_hs) begin
          awready_d = 1'b0;
          wready_d  = 1'b1;
          w_state_d = W_COLLECT;
        end else if (w_hs) begin
          awready_d = 1'b1;
          wready_d  = 1'b0;
          w_state_d = W_COLLECT;
        end else begin
          awready_d = 1'b1;
          wready_d  = 1'b1;
        end
      end
      W_COLLECT: begin
        if (aw_hs || w_hs) begin
          commit    = 1'b1;
          awready_d = 1'b0;
          wready_d  = 1'b0;
          w_state_d = W_RESP;
        end
      end
      W_RESP: begin
        if (BREADY) begin
          bvalid_d  = 1'b0;
          awready_d = 1'b1;
          wready_d  = 1'b1;
          w_state_d = W_IDLE;
        end
      end
      default: w_state_d = W_IDLE;
    endcase

    if (commit) begin
      bvalid_d = 1'b1;
      bresp_d  = {SLVERR_EN & awslot_d[2], 1'b0};
      if (!awslot_d[2]) begin
        for (int b = 0; b < SW; b++) begin
          if (wstrb_d[b]) reg_d[awslot_d[1:0]][8*b +: 8] = wdata_d[8*b +: 8];
        end
      end
    end
  end

  // Reads sample reg_q, so a same-cycle write commit is not yet visible.
  always_comb begin
    r_state_d = r_state_q;
    arready_d = arready_q;
    rvalid_d  = rvalid_q;
    rresp_d   = rresp_q;
    rdata_d   = rdata_q;
    case (r_state_q)
      R_IDLE: begin
        if (ar_hs) begin
          rdata_d   = arslot[2] ? '0 : reg_q[arslot[1:0]];
          rresp_d   = {SLVERR_EN & arslot[2], 1'b0};
          rvalid_d  = 1'b1;
          arready_d = 1'b0;
          r_state_d = R_DATA;
        end else begin
          arready_d = 1'b1;
        end
      end
      R_DATA: begin
        if (RREADY) begin
          rvalid_d  = 1'b0;
          arready_d = 1'b1;
          r_state_d = R_IDLE;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      w_state_q <= W_IDLE;
      r_state_q <= R_IDLE;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= 2'b00;
      awslot_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rresp_q   <= 2'b00;
      rdata_q   <= '0;
      for (int i = 0; i < 4; i++) reg_q[i] <= '0;
    end else begin
      w_state_q <= w_state_d;
      r_state_q <= r_state_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      awslot_q  <= awslot_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rresp_q   <= rresp_d;
      rdata_q   <= rdata_d;
      for (int i = 0; i < 4; i++) reg_q[i] <= reg_d[i];
    end
  end

  assign AWREADY  = awready_q;
  assign WREADY   = wready_q;
  assign BVALID   = bvalid_q;
  assign BRESP    = bresp_q;
  assign ARREADY  = arready_q;
  assign RVALID   = rvalid_q;
  assign RRESP    = rresp_q;
  assign RDATA    = rdata_q;
  assign slv_reg0 = reg_q[0];
  assign slv_reg1 = reg_q[1];
  assign slv_reg2 = reg_q[2];
  assign slv_reg3 = reg_q[3];

endmodule

// File: tb/tb_mem_ctrl_axil_regs.sv
// Directed self-checking bench for mem_ctrl_axil_regs; honours MEM_CTRL_AXIL_SLVERR_EN.
module tb_mem_ctrl_axil_regs;

  localparam logic [1:0] OKAY = 2'b00;
`ifdef MEM_CTRL_AXIL_SLVERR_EN
  localparam logic [1:0] UNMAP_RESP = 2'b10;
`else
  localparam logic [1:0] UNMAP_RESP = 2'b00;
`endif

  logic        ACLK, ARESETN;
  logic [4:0]  AWADDR, ARADDR;
  logic [2:0]  AWPROT, ARPROT;
  logic        AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
  logic        ARVALID, ARREADY, RVALID, RREADY;
  logic [31:0] WDATA, RDATA, slv_reg0, slv_reg1, slv_reg2, slv_reg3;
  logic [3:0]  WSTRB;
  logic [1:0]  BRESP, RRESP;

  logic [31:0] exp_reg [4];
  int vecs = 0;
  int errs = 0;

  mem_ctrl_axil_regs dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .AWADDR(AWADDR), .AWPROT(AWPROT), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARPROT(ARPROT), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
    .slv_reg0(slv_reg0), .slv_reg1(slv_reg1), .slv_reg2(slv_reg2), .slv_reg3(slv_reg3)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check_regs(input string tag);
    check({tag, "_slv_reg0"}, slv_reg0, exp_reg[0]);
    check({tag, "_slv_reg1"}, slv_reg1, exp_reg[1]);
    check({tag, "_slv_reg2"}, slv_reg2, exp_reg[2]);
    check({tag, "_slv_reg3"}, slv_reg3, exp_reg[3]);
  endtask

  task automatic axi_write(input logic [4:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int aw_dly, input int w_dly, input int hold, input logic [1:0] exp_resp);
    int cyc = 0;
    bit aw_done = 0, w_done = 0, aw_fire, w_fire, early_b = 0, ready_bad = 0, stable = 1;
    logic [1:0] resp0;
    AWADDR = addr; WDATA = data; WSTRB = strb;
    while (!(aw_done && w_done) && cyc < 30) begin
      AWVALID = !aw_done && (cyc >= aw_dly);
      WVALID  = !w_done && (cyc >= w_dly);
      aw_fire = AWVALID && AWREADY;
      w_fire  = WVALID && WREADY;
      if (BVALID) early_b = 1;
      if ((aw_done && AWREADY) || (w_done && WREADY)) ready_bad = 1;
      @(posedge ACLK); #1;
      if (aw_fire) aw_done = 1;
      if (w_fire) w_done = 1;
      cyc++;
    end
    AWVALID = 0; WVALID = 0;
    check("wr_handshakes", {30'd0, aw_done, w_done}, 32'd3);
    check("wr_no_early_bvalid", {31'd0, early_b}, 32'd0);
    check("wr_ready_low_after_hs", {31'd0, ready_bad}, 32'd0);
    check("wr_bvalid_latency", {31'd0, BVALID}, 32'd1);
    check("wr_bresp", {30'd0, BRESP}, {30'd0, exp_resp});
    if (!addr[4])
      for (int b = 0; b < 4; b++) if (strb[b]) exp_reg[addr[3:2]][8*b +: 8] = data[8*b +: 8];
    resp0 = BRESP;
    BREADY = 0;
    for (int h = 0; h < hold; h++) begin
      AWVALID = 1; WVALID = 1;
      @(posedge ACLK); #1;
      if (!BVALID || BRESP !== resp0 || AWREADY || WREADY) stable = 0;
    end
    AWVALID = 0; WVALID = 0;
    if (hold > 0) check("wr_b_hold_stable", {31'd0, stable}, 32'd1);
    BREADY = 1;
    @(posedge ACLK); #1;
    BREADY = 0;
    check("wr_bvalid_drop", {31'd0, BVALID}, 32'd0);
    check("wr_ready_return", {30'd0, AWREADY, WREADY}, 32'd3);
  endtask

  task automatic axi_read(input logic [4:0] addr, input logic [31:0] exp_data,
                          input logic [1:0] exp_resp, input int hold);
    int cyc = 0;
    bit fired = 0, f, stable = 1;
    logic [31:0] d0;
    ARADDR = addr; ARVALID = 1;
    while (!fired && cyc < 30) begin
      f = ARREADY;
      @(posedge ACLK); #1;
      if (f) fired = 1;
      cyc++;
    end
    ARVALID = 0;
    check("rd_handshake", {31'd0, fired}, 32'd1);
    check("rd_rvalid_latency", {31'd0, RVALID}, 32'd1);
    check("rd_rdata", RDATA, exp_data);
    check("rd_rresp", {30'd0, RRESP}, {30'd0, exp_resp});
    d0 = RDATA;
    RREADY = 0;
    for (int h = 0; h < hold; h++) begin
      ARVALID = 1;
      @(posedge ACLK); #1;
      if (!RVALID || RDATA !== d0 || RRESP !== exp_resp || ARREADY) stable = 0;
    end
    ARVALID = 0;
    if (hold > 0) check("rd_r_hold_stable", {31'd0, stable}, 32'd1);
    RREADY = 1;
    @(posedge ACLK); #1;
    RREADY = 0;
    check("rd_rvalid_drop", {31'd0, RVALID}, 32'd0);
    check("rd_arready_return", {31'd0, ARREADY}, 32'd1);
  endtask

  initial begin
    ARESETN = 0;
    AWADDR = 0; AWPROT = 0; AWVALID = 0; WDATA = 0; WSTRB = 0; WVALID = 0; BREADY = 0;
    ARADDR = 0; ARPROT = 3'b101; ARVALID = 0; RREADY = 0;
    for (int i = 0; i < 4; i++) exp_reg[i] = 32'd0;

    // reset state
    repeat (3) @(posedge ACLK);
    #1;
    check("rst_handshake_outs", {25'd0, AWREADY, WREADY, ARREADY, BVALID, RVALID, BRESP[1], RRESP[1]}, 32'd0);
    check("rst_resps", {28'd0, BRESP, RRESP}, 32'd0);
    check("rst_rdata", RDATA, 32'd0);
    check_regs("rst");
    ARESETN = 1;
    #1;
    check("ready_before_first_edge", {29'd0, AWREADY, WREADY, ARREADY}, 32'd0);
    @(posedge ACLK); #1;
    check("ready_after_first_edge", {29'd0, AWREADY, WREADY, ARREADY}, 32'd7);

    // basic write / read back, AWPROT toggled to show it is ignored
    AWPROT = 3'b111;
    axi_write(5'h00, 32'h1, 4'hF, 0, 0, 0, OKAY);
    axi_write(5'h04, 32'h2, 4'hF, 0, 0, 0, OKAY);
    axi_write(5'h08, 32'h3, 4'hF, 0, 0, 0, OKAY);
    axi_write(5'h0C, 32'h4, 4'hF, 0, 0, 0, OKAY);
    check_regs("basic");
    axi_read(5'h00, 32'h1, OKAY, 0);
    axi_read(5'h04, 32'h2, OKAY, 0);
    axi_read(5'h08, 32'h3, OKAY, 0);
    axi_read(5'h0C, 32'h4, OKAY, 0);

    // read and write commit to the same register in the same cycle
    AWADDR = 5'h08; WDATA = 32'h77; WSTRB = 4'hF; ARADDR = 5'h08;
    AWVALID = 1; WVALID = 1; ARVALID = 1;
    @(posedge ACLK); #1;
    AWVALID = 0; WVALID = 0; ARVALID = 0;
    exp_reg[2] = 32'h77;
    check("same_cycle_bvalid", {31'd0, BVALID}, 32'd1);
    check("same_cycle_rvalid", {31'd0, RVALID}, 32'd1);
    check("same_cycle_rdata_prewrite", RDATA, 32'h3);
    check("same_cycle_slv_reg2", slv_reg2, 32'h77);
    BREADY = 1; RREADY = 1;
    @(posedge ACLK); #1;
    BREADY = 0; RREADY = 0;
    check("same_cycle_idle", {28'd0, AWREADY, WREADY, ARREADY, BVALID | RVALID}, 32'he);

    // AW leads W by 3 cycles, then W leads AW
    axi_write(5'h04, 32'h0000_00A5, 4'hF, 0, 3, 0, OKAY);
    check_regs("aw_first");
    axi_write(5'h0C, 32'h0000_005A, 4'hF, 2, 0, 0, OKAY);
    check_regs("w_first");

    // byte strobes
    axi_write(5'h04, 32'hAABBCCDD, 4'hF, 0, 0, 0, OKAY);
    axi_write(5'h04, 32'h11223344, 4'h5, 0, 0, 0, OKAY);
    check("strb_slv_reg1", slv_reg1, 32'hAA22CC44);

    // byte offset bits ignored
    axi_write(5'h03, 32'hCAFE0001, 4'hF, 0, 0, 0, OKAY);
    check_regs("low_addr_bits");
    axi_read(5'h02, 32'hCAFE0001, OKAY, 0);

    // backpressure on B and R
    axi_write(5'h08, 32'h0BAD_F00D, 4'h3, 0, 0, 5, OKAY);
    check_regs("bp");
    axi_read(5'h08, exp_reg[2], OKAY, 5);

    // unmapped slot
    axi_write(5'h14, 32'hFFFFFFFF, 4'hF, 0, 0, 0, UNMAP_RESP);
    check_regs("unmapped_wr");
    axi_read(5'h14, 32'h0, UNMAP_RESP, 0);
    axi_read(5'h1C, 32'h0, UNMAP_RESP, 2);

    // reset while BVALID is pending
    AWADDR = 5'h08; WDATA = 32'h5; WSTRB = 4'hF;
    AWVALID = 1; WVALID = 1;
    @(posedge ACLK); #1;
    AWVALID = 0; WVALID = 0;
    check("pre_reset_bvalid", {31'd0, BVALID}, 32'd1);
    check("pre_reset_slv_reg2", slv_reg2, 32'h5);
    ARESETN = 0;
    #1;
    for (int i = 0; i < 4; i++) exp_reg[i] = 32'd0;
    check("async_rst_outs", {25'd0, AWREADY, WREADY, ARREADY, BVALID, RVALID, BRESP[1], RRESP[1]}, 32'd0);
    check("async_rst_rdata", RDATA, 32'd0);
    check_regs("async_rst");
    repeat (2) @(posedge ACLK);
    #1;
    ARESETN = 1;
    @(posedge ACLK); #1;
    check("post_reset_no_bvalid", {31'd0, BVALID}, 32'd0);
    axi_read(5'h08, 32'h0, OKAY, 0);
    check_regs("post_reset");

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/mem_ctrl_axil_regs.md
MEM_CTRL_AXIL_REGS -- requirements
Module: mem_ctrl_axil_regs

Interface
REQ-001 The module SHALL have parameter C_S_AXI_DATA_WIDTH, default 32, the AXI4-Lite data width (only 32 supported).
REQ-002 The module SHALL have parameter C_S_AXI_ADDR_WIDTH, default 5, the byte address width (8 word slots).
REQ-003 The module SHALL have port ACLK, input, 1 bit: the single clock; all logic is rising-edge.
REQ-004 The module SHALL have port ARESETN, input, 1 bit: asynchronous, active-low reset.
REQ-005 The module SHALL have ports AWADDR in [ADDR_WIDTH-1:0], AWPROT in 3, AWVALID in 1, AWREADY out 1: the write address channel.
REQ-006 The module SHALL have ports WDATA in 32, WSTRB in 4, WVALID in 1, WREADY out 1: the write data channel.
REQ-007 The module SHALL have ports BRESP out 2, BVALID out 1, BREADY in 1: the write response channel.
REQ-008 The module SHALL have ports ARADDR in [ADDR_WIDTH-1:0], ARPROT in 3, ARVALID in 1, ARREADY out 1: the read address channel.
REQ-009 The module SHALL have ports RDATA out 32, RRESP out 2, RVALID out 1, RREADY in 1: the read data channel.
REQ-010 The module SHALL have ports slv_reg0..slv_reg3, each out 32: current register contents, exported to the memory controller.

Function
REQ-011 Word slot = ADDR[4:2]; slots 0-3 SHALL map to slv_reg0-3 (byte offsets 0x0, 0x4, 0x8, 0xC); slots 4-7 SHALL be unmapped; ADDR[1:0] and AxPROT SHALL be ignored.
REQ-012 The write FSM SHALL have states W_IDLE, W_COLLECT, W_RESP.
REQ-013 In W_IDLE, AWREADY=1 and WREADY=1; AW and W SHALL be accepted independently, in either order or in the same cycle.
REQ-014 Once a channel handshake completes, that channel's READY SHALL be 0 until the matching BVALID/BREADY handshake; the FSM SHALL wait in W_COLLECT for the other channel.
REQ-015 On the edge after both AW and W have been captured, the targeted register SHALL update byte-wise per WSTRB (byte k from WDATA[8k+7:8k] iff WSTRB[k]=1), and BVALID SHALL rise on the same edge (W_RESP).
REQ-016 Minimum write latency SHALL be 1 cycle from simultaneous AW+W handshake to BVALID=1.
REQ-017 BVALID and BRESP SHALL stay stable until BREADY=1; the FSM SHALL then return to W_IDLE with both READYs high on the next cycle.
REQ-018 A write to an unmapped slot SHALL change no register and still complete with a B response.
REQ-019 The read FSM SHALL have states R_IDLE (ARREADY=1) and R_DATA (ARREADY=0, RVALID=1).
REQ-020 On AR handshake, RDATA SHALL be loaded from the register value present in that cycle, and RVALID SHALL rise on the next edge (1-cycle latency).
REQ-021 RDATA/RRESP SHALL stay stable while RVALID=1 and RREADY=0; on RREADY=1 the FSM SHALL return to R_IDLE.
REQ-022 Unmapped reads SHALL return RDATA=0x00000000.
REQ-023 The read and write paths SHALL operate concurrently; if a read handshake and a write commit hit the same register in the same cycle, the read SHALL return the pre-write value.
REQ-024 At most one outstanding write and one outstanding read SHALL exist at any time.

Reset
REQ-025 ARESETN=0 SHALL asynchronously force: slv_reg0-3=0, AWREADY=0, WREADY=0, ARREADY=0, BVALID=0, RVALID=0, BRESP=00, RRESP=00, RDATA=0, FSMs to W_IDLE/R_IDLE, captured address/data cleared.
REQ-026 AWREADY, WREADY and ARREADY SHALL first assert on the first rising edge after ARESETN is sampled high.
REQ-027 A reset asserted mid-transaction SHALL abort it; no register update and no response SHALL be issued for it afterwards.

Configuration
REQ-028 Macro MEM_CTRL_AXIL_SLVERR_EN defined: accesses to unmapped slots SHALL return BRESP/RRESP=2'b10 (SLVERR). Mapped accesses SHALL return OKAY.
REQ-029 Macro not defined: all responses SHALL be 2'b00 (OKAY). All other behaviour SHALL be identical.

Verification
REQ-030 Write 0x1,0x2,0x3,0x4 to 0x0,0x4,0x8,0xC with WSTRB=0xF, then read back -> RDATA 0x1,0x2,0x3,0x4, RESP=OKAY, slv_reg0-3 match.
REQ-031 AWVALID 3 cycles before WVALID, and a separate case with WVALID first -> exactly one BVALID, 1 cycle after the later handshake; correct register written.
REQ-032 slv_reg1=0xAABBCCDD, write 0x11223344 with WSTRB=0x5 -> slv_reg1=0xAA22CC44.
REQ-033 Hold BREADY/RREADY low 5 cycles -> BVALID/RVALID, BRESP and RDATA stable throughout; no new AW/W/AR accepted.
REQ-034 Write and read to 0x14 -> no register change, RDATA=0; RESP=SLVERR with MEM_CTRL_AXIL_SLVERR_EN, OKAY without it.
REQ-035 Drop ARESETN while BVALID=1 with slv_reg2=0x5 -> all outputs 0 immediately; after release, read of 0x8 returns 0x0.
